clk_gen_param: RTL
==================

CLK_GEN_PARAM -- requirements
Module: clk_gen_param

Interface
REQ-001 The block SHALL have parameter N_STAGES, default 5, meaning the number of divided clocks, legal range 1..8.
REQ-002 The block SHALL have parameter SEL_W, default 3, meaning the width of clk_sel, fixed at max(1, clog2(N_STAGES)).
REQ-003 The block SHALL have port clk_32f  input  1  base clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port enable  input  1  high = divider advances; low = divider freezes.
REQ-006 The block SHALL have port sync_clear  input  1  synchronous active-high phase realign.
REQ-007 The block SHALL have port clk_sel  input  SEL_W  requested index for clk_out.
REQ-008 The block SHALL have port clk_div  output  N_STAGES  divided clocks; bit k has period 2^(k+1) clk_32f cycles (N_STAGES=5: bit0=16f ... bit4=f).
REQ-009 The block SHALL have port rise_stb  output  N_STAGES  one-cycle pulse per rising edge of clk_div[k].
REQ-010 The block SHALL have port clk_out  output  1  glitch-free selected divided clock.
REQ-011 The block SHALL have port locked  output  1  high once one full period of clk_div[N_STAGES-1] has completed.

Function
REQ-012 The block SHALL hold an N_STAGES-bit down counter cnt; clk_div SHALL equal cnt, and cnt SHALL decrement by 1 per enabled cycle, wrapping modulo 2^N_STAGES.
REQ-013 All outputs SHALL be registered; none SHALL be a combinational function of inputs.
REQ-014 On the first enabled edge after cnt=0, every clk_div bit SHALL go to 1 simultaneously (all clocks rise in phase).
REQ-015 rise_stb[k] SHALL be 1 in exactly the cycles where clk_div[k]=1 and clk_div[k] was 0 in the previous cycle.
REQ-016 With enable=0, cnt, clk_div and clk_out SHALL hold, rise_stb SHALL be 0, and locked SHALL hold.
REQ-017 sync_clear=1 SHALL force cnt=0, rise_stb=0, clk_out=0 and locked=0 on the next edge, regardless of enable; sel_active SHALL be kept.
REQ-018 Precedence SHALL be reset > sync_clear > enable.
REQ-019 clk_sel SHALL be captured every cycle into sel_pend; a value >= N_STAGES SHALL be ignored, leaving sel_pend unchanged.
REQ-020 sel_pend SHALL be copied to sel_active only on an enabled edge where the current cnt=0 (all clocks low), so no clk_out high or low phase is shorter than that of either clock.
REQ-021 clk_out SHALL equal clk_div[sel_active] in the same cycle, computed from the next-state counter value.
REQ-022 locked SHALL be set on the enabled edge where cnt goes from 1 to 0, i.e. 2^N_STAGES enabled edges after reset release or sync_clear, and SHALL then stay 1 until reset or sync_clear.

Reset
REQ-023 While reset=0 at an edge, the block SHALL set cnt=0, clk_div=0, rise_stb=0, clk_out=0, locked=0, sel_pend=sel_active=N_STAGES-1.
REQ-024 Reset asserted mid-operation SHALL take effect on the next edge, with no partial-period completion.

Structure
REQ-025 Package clk_gen_pkg SHALL hold N_STAGES_MAX=8, the SEL_W derivation function and the reset select constant.
REQ-026 The glitch-free selection logic (REQ-019..021) SHALL be a sub-module named clk_glitchfree_mux; the counter and strobe logic SHALL stay in clk_gen_param.

Verification (N_STAGES=5)
REQ-027 Scenario 1: reset=0 for 3 cycles, then release with enable=1 -> clk_div=11111, rise_stb=11111 at edge 1; 11110 at edge 2; bit0 period 2 and bit4 period 32 thereafter.
REQ-028 Scenario 2: same stimulus as Scenario 1 -> locked=0 through edge 31 and locked=1 at edge 32 (cnt=0), staying high.
REQ-029 Scenario 3: enable=0 after edge 10 (cnt=22) for 5 cycles -> clk_div holds 10110, rise_stb=0; the count resumes at 21 on the next enabled edge.
REQ-030 Scenario 4: clk_sel=0 from edge 5 -> clk_out tracks clk_div[4] through edge 32, then tracks clk_div[0] from edge 33; no glitch occurs.
REQ-031 Scenario 5: sync_clear pulse at cnt=13 -> next edge gives clk_div=0 and locked=0; the sequence then restarts exactly as in Scenario 1; sync_clear together with enable=0 still clears.
REQ-032 Scenario 6: clk_sel=6 or 7 -> sel_active is unchanged; clk_sel=2 held thereafter -> clk_out switches to clk_div[2] at the next cnt=0 edge.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared constants, types and helpers for the parameterised clock divider.
// Imported by clk_gen_param and clk_glitchfree_mux.
package clk_gen_pkg;

  localparam int N_STAGES_MAX = 8;

  // Stage selected out of reset: the slowest divided clock.
  localparam int RST_SEL_FROM_TOP = 1;

  typedef struct packed {
    logic adv;
    logic clr;
    logic at_zero;
  } mux_ctrl_t;

  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int rst_sel(input int n);
    return n - RST_SEL_FROM_TOP;
  endfunction

endpackage

// File: rtl/clk_glitchfree_mux.sv
// Selects one divided clock; the select only changes while all clocks are low,
// so clk_out never produces a runt high or low phase.
module clk_glitchfree_mux
  import clk_gen_pkg::*;
#(
  parameter int N_STAGES = 5,
  parameter int SEL_W    = sel_w(N_STAGES)
) (
  input  logic                clk_32f,
  input  logic                reset,
  input  mux_ctrl_t           ctrl,
  input  logic [N_STAGES-1:0] cnt_d,
  input  logic [SEL_W-1:0]    clk_sel,
  output logic                clk_out
);

  localparam logic [SEL_W:0]   N_LIM   = (SEL_W+1)'(N_STAGES);
  localparam logic [SEL_W-1:0] SEL_RST = SEL_W'(rst_sel(N_STAGES));

  logic [SEL_W-1:0] sel_pend_q;
  logic [SEL_W-1:0] sel_pend_d;
  logic [SEL_W-1:0] sel_active_q;
  logic [SEL_W-1:0] sel_active_d;
  logic             clk_out_q;
  logic             clk_out_d;
  logic             sel_ok;

  assign sel_ok = ({1'b0, clk_sel} < N_LIM);

  always_comb begin
    sel_pend_d = sel_pend_q;
    if (sel_ok) begin
      sel_pend_d = clk_sel;
    end
  end

  // Switch only on the edge leaving cnt=0, where every clock rises together.
  always_comb begin
    sel_active_d = sel_active_q;
    if (ctrl.adv && ctrl.at_zero) begin
      sel_active_d = sel_pend_q;
    end
  end

  always_comb begin
    clk_out_d = 1'b0;
    if (!ctrl.clr) begin
      clk_out_d = cnt_d[sel_active_d];
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      sel_pend_q   <= SEL_RST;
      sel_active_q <= SEL_RST;
      clk_out_q    <= 1'b0;
    end else begin
      sel_pend_q   <= sel_pend_d;
      sel_active_q <= sel_active_d;
      clk_out_q    <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

endmodule

// File: rtl/clk_gen_param.sv
// Down-counter clock divider: bit k of the counter is a clock of period
// 2^(k+1) base cycles, with registered rise strobes and a lock flag.
module clk_gen_param
  import clk_gen_pkg::*;
#(
  parameter int N_STAGES = 5,
  parameter int SEL_W    = sel_w(N_STAGES)
) (
  input  logic                clk_32f,
  input  logic                reset,
  input  logic                enable,
  input  logic                sync_clear,
  input  logic [SEL_W-1:0]    clk_sel,
  output logic [N_STAGES-1:0] clk_div,
  output logic [N_STAGES-1:0] rise_stb,
  output logic                clk_out,
  output logic                locked
);

  localparam logic [N_STAGES-1:0] ONE = N_STAGES'(1);

  logic [N_STAGES-1:0] cnt_q;
  logic [N_STAGES-1:0] cnt_d;
  logic [N_STAGES-1:0] rise_q;
  logic [N_STAGES-1:0] rise_d;
  logic                locked_q;
  logic                locked_d;
  mux_ctrl_t           ctrl;

  always_comb begin
    cnt_d    = cnt_q;
    rise_d   = '0;
    locked_d = locked_q;
    if (sync_clear) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (enable) begin
      cnt_d  = cnt_q - ONE;
      rise_d = cnt_d & ~cnt_q;
      // The 1->0 step closes the first full period of the slowest clock.
      if (cnt_q == ONE) begin
        locked_d = 1'b1;
      end
    end
  end

  always_comb begin
    ctrl.clr     = sync_clear;
    ctrl.adv     = enable & ~sync_clear;
    ctrl.at_zero = (cnt_q == '0);
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      cnt_q    <= '0;
      rise_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      locked_q <= locked_d;
    end
  end

  clk_glitchfree_mux #(
    .N_STAGES (N_STAGES),
    .SEL_W    (SEL_W)
  ) u_mux (
    .clk_32f (clk_32f),
    .reset   (reset),
    .ctrl    (ctrl),
    .cnt_d   (cnt_d),
    .clk_sel (clk_sel),
    .clk_out (clk_out)
  );

  assign clk_div  = cnt_q;
  assign rise_stb = rise_q;
  assign locked   = locked_q;

endmodule
